// File: rtl/rtc_trigger_ctrl_if.sv
// Bundle of the stopwatch controller's control/status signals.
// Signal names match the controller's external pin names.
//
// Signals:
//   i_basetick   one-cycle 10 ms tick from the timer
//   i_startstop  one-cycle debounced start/stop button pulse
//   i_lap        one-cycle debounced lap/split button pulse
//   i_clear      one-cycle debounced clear button pulse
//   i_bcdcount   live 24-bit BCD count from the counter wrapper
//   o_countenb   counter chain enable
//   o_latchcount one-cycle count strobe
//   o_countinit  one-cycle counter re-initialise pulse
//   o_dispsel    0 = live count, 1 = lap snapshot
//   o_lapcount   lap snapshot (BCD)
//   o_state      FSM state: 0 IDLE, 1 RUN, 2 STOP, 3 LAP
//
// Modports:
//   master  drives the i_* signals and observes the o_* signals
//           (buttons, timer and counter side)
//   slave   the controller itself
interface rtc_trigger_ctrl_if;
  logic        i_basetick;
  logic        i_startstop;
  logic        i_lap;
  logic        i_clear;
  logic [23:0] i_bcdcount;
  logic        o_countenb;
  logic        o_latchcount;
  logic        o_countinit;
  logic        o_dispsel;
  logic [23:0] o_lapcount;
  logic [1:0]  o_state;

  modport master (
    output i_basetick, i_startstop, i_lap, i_clear, i_bcdcount,
    input  o_countenb, o_latchcount, o_countinit, o_dispsel, o_lapcount, o_state
  );

  modport slave (
    input  i_basetick, i_startstop, i_lap, i_clear, i_bcdcount,
    output o_countenb, o_latchcount, o_countinit, o_dispsel, o_lapcount, o_state
  );
endinterface

// File: rtl/rtc_trigger_ctrl.sv
// Stopwatch control FSM. It sequences the cascaded BCD digit counters from
// debounced button pulses and the 10 ms base tick, and it keeps a lap/split
// snapshot that is shown for LAP_HOLD_TICKS ticks before the display returns
// to the live count.
//
// Ports:
//   i_rtcclk  system clock
//   i_reset   synchronous, active-high reset
//   bus       rtc_trigger_ctrl_if.slave. It carries the tick, button and
//             count inputs and the enable, strobe, init, display-select,
//             snapshot and state outputs.
//
// Event priority within one cycle:
//   reset > clear > auto-stop at full scale > start/stop > lap.
// All outputs are registered.
module rtc_trigger_ctrl #(
  parameter int unsigned LAP_HOLD_TICKS = 300,
  parameter logic [23:0] MAX_BCD        = 24'h595999
) (
  input  logic              i_rtcclk,
  input  logic              i_reset,
  rtc_trigger_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } state_t;

  localparam logic [9:0] HOLD_LOAD = 10'(LAP_HOLD_TICKS);

  state_t      state_q;
  logic        countenb_q;
  logic        latch_q;
  logic        init_q;
  logic        dispsel_q;
  logic [23:0] lapcount_q;
  logic [9:0]  hold_q;

  logic running;
  logic at_max;
  logic auto_stop;

  assign running   = (state_q == RUN) || (state_q == LAP);
  assign at_max    = (bus.i_bcdcount == MAX_BCD);
  // Stopping on the tick that sees full scale stops the counter from
  // wrapping to 00:00.00.
  assign auto_stop = running && bus.i_basetick && at_max;

  always_ff @(posedge i_rtcclk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      countenb_q <= 1'b0;
      latch_q    <= 1'b0;
      init_q     <= 1'b0;
      dispsel_q  <= 1'b0;
      lapcount_q <= '0;
      hold_q     <= '0;
    end else begin
      // The strobe depends only on the state the tick was seen in. A tick
      // that arrives with the start press gives no strobe. A tick that
      // arrives with the stop press still gives one.
      latch_q <= bus.i_basetick && running && !at_max;
      init_q  <= 1'b0;

      if (bus.i_clear) begin
        state_q    <= IDLE;
        countenb_q <= 1'b0;
        init_q     <= 1'b1;
        dispsel_q  <= 1'b0;
        lapcount_q <= '0;
        hold_q     <= '0;
      end else if (auto_stop) begin
        state_q    <= STOP;
        countenb_q <= 1'b0;
        dispsel_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.i_startstop) begin
              state_q    <= RUN;
              countenb_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.i_startstop) begin
              state_q    <= STOP;
              countenb_q <= 1'b0;
            end else if (bus.i_lap) begin
              state_q    <= LAP;
              lapcount_q <= bus.i_bcdcount;
              hold_q     <= HOLD_LOAD;
              dispsel_q  <= 1'b1;
            end
          end
          LAP: begin
            if (bus.i_startstop) begin
              // The frozen lap stays on the display while stopped.
              state_q    <= STOP;
              countenb_q <= 1'b0;
            end else if (bus.i_lap) begin
              lapcount_q <= bus.i_bcdcount;
              hold_q     <= HOLD_LOAD;
            end else if (bus.i_basetick) begin
              // The hold counter saturates at zero. Reaching zero returns
              // the display to the live count.
              if (hold_q <= 10'd1) begin
                hold_q    <= '0;
                state_q   <= RUN;
                dispsel_q <= 1'b0;
              end else begin
                hold_q <= hold_q - 10'd1;
              end
            end
          end
          STOP: begin
            if (bus.i_startstop) begin
              state_q    <= RUN;
              countenb_q <= 1'b1;
              dispsel_q  <= 1'b0;
            end else if (bus.i_lap) begin
              dispsel_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_countenb   = countenb_q;
  assign bus.o_latchcount = latch_q;
  assign bus.o_countinit  = init_q;
  assign bus.o_dispsel    = dispsel_q;
  assign bus.o_lapcount   = lapcount_q;

endmodule

// File: tb/tb_rtc_trigger_ctrl.sv
module tb_rtc_trigger_ctrl;
  localparam int          HOLD = 4;
  localparam logic [23:0] MAXV = 24'h595999;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rtc_trigger_ctrl_if bus ();

  rtc_trigger_ctrl #(.LAP_HOLD_TICKS(HOLD), .MAX_BCD(MAXV)) dut (
    .i_rtcclk(clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The model first decides which single event wins this cycle, then
  // applies that event's effect to an abstract stopwatch description.
  typedef enum int {EV_NONE, EV_CLEAR, EV_FULL, EV_SS, EV_LAP, EV_TICK} ev_t;
  int          m_state;   // 0 idle, 1 run, 2 stop, 3 lap
  bit          m_en, m_latch, m_init, m_disp;
  logic [23:0] m_snap;
  int          m_hold;
  bit          synced = 0;

  task automatic model_step(input bit rs, tk, ss, lp, cl, input logic [23:0] bcd);
    bit  counting;
    ev_t ev;
    counting = (m_state == 1) || (m_state == 3);
    if (rs) begin
      synced = 1;
      m_state = 0; m_en = 0; m_latch = 0; m_init = 0; m_disp = 0; m_snap = 0; m_hold = 0;
      return;
    end
    m_latch = counting && tk && (bcd != MAXV);
    m_init  = 0;
    if (cl)                              ev = EV_CLEAR;
    else if (counting && tk && bcd == MAXV) ev = EV_FULL;
    else if (ss)                         ev = EV_SS;
    else if (lp && m_state != 0)         ev = EV_LAP;
    else if (tk && m_state == 3)         ev = EV_TICK;
    else                                 ev = EV_NONE;
    case (ev)
      EV_CLEAR: begin m_state = 0; m_init = 1; m_disp = 0; m_snap = 0; m_hold = 0; end
      EV_FULL:  begin m_state = 2; m_disp = 0; end
      EV_SS: begin
        if (m_state == 2) m_disp = 0;
        m_state = (m_state == 0 || m_state == 2) ? 1 : 2;
      end
      EV_LAP: begin
        if (m_state == 2) m_disp = 0;
        else begin m_state = 3; m_snap = bcd; m_hold = HOLD; m_disp = 1; end
      end
      EV_TICK: begin
        m_hold = (m_hold > 0) ? m_hold - 1 : 0;
        if (m_hold == 0) begin m_state = 1; m_disp = 0; end
      end
      default: ;
    endcase
    m_en = (m_state == 1) || (m_state == 3);
  endtask

  // Compare process: model advances on each edge, outputs checked 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, bus.i_basetick, bus.i_startstop, bus.i_lap, bus.i_clear, bus.i_bcdcount);
      #1;
      if (synced) begin
        chk("m_state",    32'(bus.o_state),      32'(m_state));
        chk("m_countenb", 32'(bus.o_countenb),   32'(m_en));
        chk("m_latch",    32'(bus.o_latchcount), 32'(m_latch));
        chk("m_init",     32'(bus.o_countinit),  32'(m_init));
        chk("m_dispsel",  32'(bus.o_dispsel),    32'(m_disp));
        chk("m_lapcount", 32'(bus.o_lapcount),   32'(m_snap));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit tk, ss, lp, cl, rs);
    bus.i_basetick = tk; bus.i_startstop = ss; bus.i_lap = lp; bus.i_clear = cl; rst = rs;
    @(negedge clk);
    bus.i_basetick = 0; bus.i_startstop = 0; bus.i_lap = 0; bus.i_clear = 0; rst = 0;
  endtask

  initial begin
    int strobes;
    rst = 1;
    bus.i_basetick = 0; bus.i_startstop = 0; bus.i_lap = 0; bus.i_clear = 0;
    bus.i_bcdcount = 24'h000000;
    @(negedge clk); @(negedge clk);
    rst = 0;

    // reset state
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_en", 32'(bus.o_countenb), 0);
    chk("rst_disp", 32'(bus.o_dispsel), 0);
    chk("rst_lap", 32'(bus.o_lapcount), 0);

    // start, then five ticks -> five strobes, one cycle after each tick
    step(0, 1, 0, 0, 0);
    chk("run_state", 32'(bus.o_state), 1);
    chk("run_en", 32'(bus.o_countenb), 1);
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
      strobes += int'(bus.o_latchcount);
    end
    step(0, 0, 0, 0, 0);
    chk("strobe_count", 32'(strobes), 5);
    chk("strobe_quiet", 32'(bus.o_latchcount), 0);

    // lap snapshot and timed return
    bus.i_bcdcount = 24'h000123;
    step(0, 0, 1, 0, 0);
    chk("lap_state", 32'(bus.o_state), 3);
    chk("lap_snap", 32'(bus.o_lapcount), 32'h000123);
    chk("lap_disp", 32'(bus.o_dispsel), 1);
    for (int i = 0; i < HOLD - 1; i++) step(1, 0, 0, 0, 0);
    chk("lap_hold", 32'(bus.o_state), 3);
    step(1, 0, 0, 0, 0);
    chk("lap_ret_state", 32'(bus.o_state), 1);
    chk("lap_ret_disp", 32'(bus.o_dispsel), 0);

    // stop coincident with tick -> final strobe
    step(1, 1, 0, 0, 0);
    chk("stop_state", 32'(bus.o_state), 2);
    chk("stop_en", 32'(bus.o_countenb), 0);
    chk("stop_strobe", 32'(bus.o_latchcount), 1);
    step(0, 0, 0, 1, 0);
    chk("clr_init", 32'(bus.o_countinit), 1);
    chk("clr_state", 32'(bus.o_state), 0);
    chk("clr_lap", 32'(bus.o_lapcount), 0);
    step(0, 0, 0, 0, 0);
    chk("clr_init_1cyc", 32'(bus.o_countinit), 0);

    // auto-stop at full scale
    step(0, 1, 0, 0, 0);
    bus.i_bcdcount = MAXV;
    step(1, 0, 0, 0, 0);
    chk("max_nostrobe", 32'(bus.o_latchcount), 0);
    chk("max_state", 32'(bus.o_state), 2);
    chk("max_disp", 32'(bus.o_dispsel), 0);

    // clear beats startstop in LAP
    bus.i_bcdcount = 24'h000200;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("lap2_disp", 32'(bus.o_dispsel), 1);
    step(0, 1, 0, 1, 0);
    chk("clrwin_state", 32'(bus.o_state), 0);
    chk("clrwin_init", 32'(bus.o_countinit), 1);
    chk("clrwin_disp", 32'(bus.o_dispsel), 0);

    // reset during LAP with tick
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rst2_state", 32'(bus.o_state), 0);
    chk("rst2_strobe", 32'(bus.o_latchcount), 0);
    chk("rst2_en", 32'(bus.o_countenb), 0);
    chk("rst2_disp", 32'(bus.o_dispsel), 0);
    chk("rst2_lap", 32'(bus.o_lapcount), 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      bus.i_basetick  = ($urandom_range(0, 99) < 30);
      bus.i_startstop = ($urandom_range(0, 99) < 3);
      bus.i_lap       = ($urandom_range(0, 99) < 4);
      bus.i_clear     = ($urandom_range(0, 99) < 1);
      rst             = ($urandom_range(0, 199) == 0);
      bus.i_bcdcount  = ($urandom_range(0, 99) < 8) ? MAXV : 24'($urandom);
      @(negedge clk);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
